// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction-fetch port
// (port 0) and a load/store port (port 1). One transaction = one IDLE issue
// cycle followed by one ACK cycle in which the winner sees a ready pulse.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   m0_* / m1_*              requester ports (addr, wdata, wmask, rstrb in;
//                            rdata, ready out)
//   mem_*                    RAM side (addr, wdata, wmask, rstrb out; rdata in)
//   busy                     high while in ACK
//   grant                    current/last granted port (round-robin pointer)
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_rstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_rstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant
);

    localparam int unsigned MW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;

    logic req0_c, req1_c, rd0_c, rd1_c, winner_c;

    // A nonzero write mask makes the transaction a write; rstrb is ignored.
    assign req0_c = m0_rstrb | (|m0_wmask);
    assign req1_c = m1_rstrb | (|m1_wmask);
    assign rd0_c  = m0_rstrb & ~(|m0_wmask);
    assign rd1_c  = m1_rstrb & ~(|m1_wmask);

    // Tie goes to port 1 in fixed mode, otherwise to the port not granted last.
    always_comb begin
        winner_c = 1'b0;
        if (req0_c && req1_c) begin
            winner_c = FIXED_PRIO ? 1'b1 : ~grant_q;
        end else if (req1_c) begin
            winner_c = 1'b1;
        end
    end

    // State and round-robin pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next state and RAM-side drive.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wmask = MW'(0);
        mem_rstrb = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_c) begin
                    mem_addr  = m1_addr;
                    mem_wdata = m1_wdata;
                end
                if (req0_c || req1_c) begin
                    mem_wmask = winner_c ? m1_wmask : m0_wmask;
                    mem_rstrb = winner_c ? rd1_c : rd0_c;
                    grant_d   = winner_c;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (grant_q) begin
                    mem_addr  = m1_addr;
                    mem_wdata = m1_wdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs come from registered state only.
    assign busy     = (state_q == ACK);
    assign grant    = grant_q;
    assign m0_ready = (state_q == ACK) & ~grant_q;
    assign m1_ready = (state_q == ACK) &  grant_q;
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port SOC RAM between the processor's instruction-fetch port (port 0) and its load/store data port (port 1). It sits between the Processor and Memory in the SOC. Each access is one transaction: the arbiter grants one requester, forwards the address, read strobe and write strobes to RAM, and returns a one-cycle `ready` pulse with read data. Arbitration is round-robin, with a fixed-priority option.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes port 1 always win a simultaneous request.
- `clk` in 1: system clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `m0_addr` in 32: port 0 byte address.
- `m0_wdata` in 32: port 0 write data.
- `m0_wmask` in 4: port 0 byte write enables.
- `m0_rstrb` in 1: port 0 read request.
- `m0_rdata` out 32: port 0 read data.
- `m0_ready` out 1: port 0 transaction complete.
- `m1_addr`, `m1_wdata`, `m1_wmask`, `m1_rstrb`, `m1_rdata`, `m1_ready`: port 1, same widths and meanings.
- `mem_addr` out 32: RAM byte address; RAM indexes words with `[31:2]`.
- `mem_wdata` out 32: RAM write data.
- `mem_wmask` out 4: RAM byte write enables; the write commits at the clock edge.
- `mem_rstrb` out 1: RAM read strobe; `mem_rdata` is valid the following cycle.
- `mem_rdata` in 32: RAM registered read data; RAM holds it while `mem_rstrb` is low.
- `busy` out 1: high in the ACK state.
- `grant` out 1: index of the current or last granted port.

## Operation
- Request on port N is `mN_rstrb | (|mN_wmask)`.
- A requester holds addr, wdata, wmask and rstrb stable until it samples `mN_ready` high, then deasserts on that same edge.
- If `mN_wmask` is nonzero, the transaction is a write and `mN_rstrb` is ignored: `mem_rstrb`=0 for that transaction.
- FSM states:
  - IDLE: if no request, stay; all `mem_*` strobes are 0.
  - IDLE with one or more requests: choose the winner combinationally. Drive `mem_addr`, `mem_wdata` and `mem_wmask` from the winner. Drive `mem_rstrb` = winner read. Register `grant` = winner and go to ACK.
  - ACK: `mem_wmask`=0 and `mem_rstrb`=0. `mem_addr` and `mem_wdata` follow the port selected by `grant`. Assert `m[grant]_ready`=1. Return to IDLE unconditionally.
- `grant` stores the last winner and is the round-robin pointer.
- Winner selection for a simultaneous request:
  - With `FIXED_PRIO`=0, the winner is the port other than the stored `grant`.
  - With `FIXED_PRIO`=1, the winner is port 1.
  - A single requester always wins.
- `m0_rdata` and `m1_rdata` both equal `mem_rdata` at all times; data is meaningful only while that port's `ready` is high.
- No new grant is made in ACK, so a request that arrives during ACK is evaluated in the next IDLE cycle.
- Starvation bound in round-robin mode: a held request is granted within 4 cycles (one other transaction first).

## Timing
- Reset values: state=IDLE, `grant`=1 (port 0 wins the first tie), `busy`=0, both `ready`=0, `mem_rstrb`=0, `mem_wmask`=0.
- In IDLE with no request, `mem_addr` and `mem_wdata` are driven from port 0.
- Latency:
  - A request present in IDLE at cycle T is issued to RAM in cycle T.
  - `ready` is high in cycle T+1. Read data is valid in cycle T+1.
  - A write is committed at the T→T+1 edge.
- Throughput: one transaction per 2 cycles. Back-to-back requests from both ports alternate.
- `ready` and `busy` are decoded from registered state only, with no combinational path from inputs. `mem_*` outputs are combinational from inputs in IDLE.
- Asserting `resetn` low mid-transaction:
  - The FSM returns to IDLE immediately and `ready` goes low asynchronously.
  - A write already committed at a prior edge stays committed.
  - A read that has not seen `ready` is lost; the requester must reissue it.
- A requester that drops its request in IDLE before the edge is not granted. Dropping during ACK is legal.

## Test plan
- Port 0 read only, RAM word 2 = 0x00000013, `m0_addr`=8 → `mem_rstrb`=1 in the issue cycle; next cycle `m0_ready`=1 and `m0_rdata`=0x00000013; `m1_ready` stays 0.
- Port 1 write, `m1_addr`=0x40, `wdata`=0xDEADBEEF, `wmask`=4'b1111, then a port 1 read of 0x40 → read returns 0xDEADBEEF; `mem_rstrb`=0 during the write transaction.
- Both ports request continuously from reset with `FIXED_PRIO`=0 → grant order 0,1,0,1; each `ready` pulse is one cycle wide, spaced 2 cycles apart.
- Same stimulus with `FIXED_PRIO`=1 → port 1 is granted every transaction while it requests; port 0 is granted only after port 1 drops.
- Port 1 with `wmask`=4'b0011 and `rstrb`=1 → `mem_wmask`=4'b0011, `mem_rstrb`=0, `ready` after 1 cycle.
- `resetn` pulsed low during ACK of a port 0 read → `m0_ready` drops immediately, state=IDLE, `grant`=1; the reissued read completes normally with correct data.
